// File: rtl/pipelined_wallace_adder_if.sv
// Handshake bundle for pipelined_wallace_adder: operand-set input channel and result output channel.
interface pipelined_wallace_adder_if #(
  parameter int unsigned N_OPS = 6,
  parameter int unsigned W     = 8,
  parameter int unsigned TAG_W = 4
);
  localparam int unsigned OW = W + $clog2(N_OPS);

  logic                 in_valid;
  logic                 in_ready;
  logic [N_OPS*W-1:0]   in_ops;
  logic                 in_signed;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [OW-1:0]        out_sum;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, in_ops, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_tag
  );

  modport slave (
    input  in_valid, in_ops, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_tag
  );
endinterface

// File: rtl/pipelined_wallace_adder.sv
// Three-stage multi-operand adder: operand capture, carry-save (Wallace) reduction, carry-propagate add.
// Valid/ready flow control with bubble collapsing; the tag and signed flag travel with each set.
module pipelined_wallace_adder #(
  parameter int unsigned N_OPS = 6,
  parameter int unsigned W     = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pipelined_wallace_adder_if.slave bus
);
  localparam int unsigned OW    = W + $clog2(N_OPS);
  localparam int unsigned OPS_W = N_OPS * W;

  // Number of 3:2 compression levels needed to bring n rows down to two.
  function automatic int unsigned csa_levels(input int unsigned n);
    int unsigned c;
    int unsigned l;
    c = n;
    l = 0;
    while (c > 2) begin
      c = 2 * (c / 3) + c % 3;
      l++;
    end
    return l;
  endfunction

  localparam int unsigned LEVELS = csa_levels(N_OPS);

  function automatic logic [OW-1:0] extend(input logic [W-1:0] op, input logic sgn);
    return sgn ? {{(OW - W){op[W-1]}}, op} : {{(OW - W){1'b0}}, op};
  endfunction

  logic                 s1_valid;
  logic [OPS_W-1:0]     s1_ops;
  logic                 s1_signed;
  logic [TAG_W-1:0]     s1_tag;
  logic                 s2_valid;
  logic [OW-1:0]        s2_sum;
  logic [OW-1:0]        s2_carry;
  logic [TAG_W-1:0]     s2_tag;
  logic                 s3_valid;
  logic [OW-1:0]        s3_sum;
  logic [TAG_W-1:0]     s3_tag;

  logic                 s1_load;
  logic                 s2_load;
  logic                 s3_load;

  logic [OW-1:0]        row [N_OPS];
  logic [OW-1:0]        nxt [N_OPS];
  int unsigned          cnt;
  int unsigned          grp;
  logic [OW-1:0]        csa_sum;
  logic [OW-1:0]        csa_carry;

  // Ready chain: a stage loads when empty or when its contents leave this cycle.
  assign s3_load      = !s3_valid || bus.out_ready;
  assign s2_load      = !s2_valid || s3_load;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;

  assign bus.out_valid = s3_valid;
  assign bus.out_sum   = s3_sum;
  assign bus.out_tag   = s3_tag;

  // Wallace reduction; the last level leaves its carry unshifted, the CPA applies the shift.
  always_comb begin
    for (int unsigned i = 0; i < N_OPS; i++) begin
      row[i] = extend(s1_ops[i*W +: W], s1_signed);
      nxt[i] = '0;
    end
    cnt = N_OPS;
    grp = 0;
    for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
      grp = cnt / 3;
      for (int unsigned i = 0; i < N_OPS; i++) nxt[i] = '0;
      for (int unsigned g = 0; g < N_OPS / 3; g++) begin
        if (g < grp) begin
          nxt[2*g] = row[3*g] ^ row[3*g+1] ^ row[3*g+2];
          nxt[2*g+1] = (row[3*g] & row[3*g+1]) | (row[3*g] & row[3*g+2]) |
                       (row[3*g+1] & row[3*g+2]);
          if (lvl != LEVELS - 1) nxt[2*g+1] = nxt[2*g+1] << 1;
        end
      end
      for (int unsigned r = 0; r < 2; r++) begin
        if (3 * grp + r < cnt) nxt[2*grp+r] = row[3*grp+r];
      end
      cnt = 2 * grp + cnt % 3;
      for (int unsigned i = 0; i < N_OPS; i++) row[i] = nxt[i];
    end
    csa_sum   = row[0];
    csa_carry = row[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_ops    <= '0;
      s1_signed <= 1'b0;
      s1_tag    <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_ops    <= bus.in_ops;
        s1_signed <= bus.in_signed;
        s1_tag    <= bus.in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_carry <= '0;
      s2_tag   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum   <= csa_sum;
        s2_carry <= csa_carry;
        s2_tag   <= s1_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_sum   <= '0;
      s3_tag   <= '0;
    end else if (s3_load) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_sum <= s2_sum + {s2_carry[OW-2:0], 1'b0};
        s3_tag <= s2_tag;
      end
    end
  end
endmodule

// File: doc/pipelined_wallace_adder.md
Name: pipelined_wallace_adder

Overview:
- Parametrised, pipelined multi-operand adder. Sums N operands of W bits through a carry-save (Wallace) reduction tree and a final carry-propagate adder.
- Generalises the fixed six-operand, 8-bit combinational tree:
  - configurable operand count and width;
  - signed/unsigned mode per transaction;
  - valid/ready handshake with backpressure;
  - sideband tag carried alongside the data.
- Sits between operand producers (e.g. partial-product generators) and downstream accumulate/writeback logic.

Parameters:
- N_OPS, 6, number of operands; legal range 3..16.
- W, 8, operand width in bits; legal range 2..32.
- TAG_W, 4, width of the sideband tag carried with each transaction; legal range 1..16.
- OW, W+$clog2(N_OPS), derived result width (11 for defaults); not overridable.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low. Assertion clears state immediately; deassertion is used synchronously to clk.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept the operand set this cycle.
- in_ops  input  N_OPS*W  operands packed; operand i = in_ops[i*W +: W].
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  OW  sum of the N_OPS operands.
- out_tag  output  TAG_W  tag of the transaction on out_sum.

Behaviour:
- Three register stages, each holding a valid bit plus payload:
  - S1: captures operands, signed flag and tag.
  - S2: CSA tree reduces the sign- or zero-extended OW-bit operands to sum and carry vectors, both registered.
  - S3: CPA adds sum + carry (carry shifted left 1; bits beyond OW discarded) and registers out_sum/out_tag.
- Transfer: in_valid&&in_ready at edge k. The result is visible with out_valid=1 after edge k+2, i.e. latency 3 cycles counting the acceptance edge. Throughput is 1 transaction per cycle when out_ready stays high.
- Stage advance:
  - Stage j loads when it is empty, or when its contents move on this cycle.
  - S3 moves when out_valid&&out_ready.
  - in_ready = !S1.valid || S1 moves. This is a combinational ready chain; no skid buffer.
- Bubbles collapse: an empty stage always loads from its predecessor, even while the output is stalled.
- Stall: while out_valid && !out_ready, out_sum and out_tag hold stable. Upstream stages keep filling until full, holding at most 3 transactions, then in_ready drops.
- Extension rule:
  - in_signed=1: each operand is sign-extended to OW bits; out_sum is two's complement.
  - in_signed=0: each operand is zero-extended.
  - The result never overflows: OW covers N_OPS*(2^W-1) and N_OPS*(-2^(W-1)).
- The signed flag and tag travel with their transaction, so mixed modes back-to-back are legal.
- Reset, at any time including mid-stream:
  - all stage valid bits, out_valid, out_sum and out_tag go to 0;
  - in-flight transactions are discarded;
  - in_ready reads 1 whenever rst_n=1 and S1 is empty.
- in_valid=0: no stage load from input; data registers may keep stale values (valid bits gate them).
- No X-propagation from in_ops when in_valid=0.

Test Plan:
- Defaults, unsigned: six operands all 8'hFF, in_tag=4'h5 -> after 3 cycles out_sum=11'd1530, out_tag=4'h5.
- Defaults, signed: six operands all 8'h80 -> out_sum=11'h500 (-768). Then six operands all 8'hFF -> out_sum=11'h7FA (-6).
- Streaming: 20 back-to-back random sets with out_ready=1 -> one result per cycle, in order, each matching the reference model; in_ready stays 1.
- Backpressure: out_ready=0 from the 2nd result while in_valid stays high -> in_ready drops after 3 transactions held. out_sum stays stable, nothing is lost or duplicated; after release, results drain in order.
- Reset mid-stream: assert rst_n=0 with 3 transactions in flight -> out_valid=0 and out_sum=0 immediately (asynchronous). After release, the first new transaction emerges with 3-cycle latency and no stale results appear.
- Parameter sweep: N_OPS=3/W=2 and N_OPS=16/W=32, random signed and unsigned sets -> all results match the model; OW=4 and OW=36 respectively.
